// File: rtl/xc_mem_txn_seq.sv
// xc_mem_txn_seq: coprocessor memory sequencer, one request -> up to 4 bus words.
// Optional alignment check: define XC_MEM_TXN_SEQ_ALIGN_CHECK_EN.
module xc_mem_txn_seq (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_count,
  input  logic         req_wen,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_ben,
  output logic         mem_cen,
  output logic         mem_wen,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_ben,
  input  logic         mem_stall,
  input  logic         mem_error,
  input  logic [31:0]  mem_rdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_rdata,
  output logic [2:0]   rsp_result,
  output logic [3:0]   log_cen,
  output logic [3:0]   log_wen,
  output logic [3:0]   log_error,
  output logic [127:0] log_addr,
  output logic [127:0] log_rdata
);

  localparam int NTXN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     idx_q;
  logic [2:0]     count_q;
  logic           wen_q;
  logic [127:0]   addr_q;
  logic [127:0]   wdata_q;
  logic [15:0]    ben_q;
  logic [2:0]     result_q;
  logic [127:0]   rsp_rdata_q;
  logic [3:0]     log_cen_q;
  logic [3:0]     log_wen_q;
  logic [3:0]     log_err_q;
  logic [127:0]   log_addr_q;
  logic [127:0]   log_rdata_q;

  logic           accept;
  logic           bad_cnt;
  logic           misal;
  logic           done;
  logic           last;

  // Checks are evaluated on the fields being latched so the verdict lands at T+1.
  assign accept  = (state_q == IDLE) && req_valid;
  assign bad_cnt = (req_count == 3'd0) || (req_count > 3'(NTXN));
  assign done    = (state_q == ISSUE) && !mem_stall;
  assign last    = ({1'b0, idx_q} == (count_q - 3'd1));

  // Misaligned detection over the slots that would be issued.
  always_comb begin
    misal = 1'b0;
`ifdef XC_MEM_TXN_SEQ_ALIGN_CHECK_EN
    for (int k = 0; k < NTXN; k++) begin
      if ((3'(k) < req_count) && (req_addr[32*k +: 2] != 2'b00)) begin
        misal = 1'b1;
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) state_d = (bad_cnt || misal) ? RESP : ISSUE;
      end
      ISSUE: begin
        if (done && (mem_error || last)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    mem_cen   = (state_q == ISSUE);
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_ben   = '0;
    if (state_q == ISSUE) begin
      mem_wen   = wen_q;
      mem_addr  = addr_q[{idx_q, 5'd0} +: 32];
      mem_wdata = wdata_q[{idx_q, 5'd0} +: 32];
      mem_ben   = ben_q[{idx_q, 2'd0} +: 4];
    end
  end

  // Request latch, slot walk, read data collection and transaction log.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      idx_q       <= '0;
      count_q     <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ben_q       <= '0;
      result_q    <= '0;
      rsp_rdata_q <= '0;
      log_cen_q   <= '0;
      log_wen_q   <= '0;
      log_err_q   <= '0;
      log_addr_q  <= '0;
      log_rdata_q <= '0;
    end else if (accept) begin
      idx_q       <= '0;
      count_q     <= req_count;
      wen_q       <= req_wen;
      addr_q      <= req_addr;
      wdata_q     <= req_wdata;
      ben_q       <= req_ben;
      rsp_rdata_q <= '0;
      log_cen_q   <= '0;
      log_wen_q   <= '0;
      log_err_q   <= '0;
      log_addr_q  <= '0;
      log_rdata_q <= '0;
      if (bad_cnt)    result_q <= 3'd3;
      else if (misal) result_q <= 3'd2;
      else            result_q <= 3'd0;
    end else if (done) begin
      log_cen_q[idx_q] <= 1'b1;
      log_wen_q[idx_q] <= wen_q;
      log_err_q[idx_q] <= mem_error;
      log_addr_q[{idx_q, 5'd0} +: 32]  <= addr_q[{idx_q, 5'd0} +: 32];
      log_rdata_q[{idx_q, 5'd0} +: 32] <= mem_rdata;
      if (!wen_q) rsp_rdata_q[{idx_q, 5'd0} +: 32] <= mem_rdata;
      if (mem_error)  result_q <= 3'd1;
      else if (!last) idx_q    <= idx_q + 2'd1;
    end
  end

  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_result = result_q;
  assign log_cen    = log_cen_q;
  assign log_wen    = log_wen_q;
  assign log_error  = log_err_q;
  assign log_addr   = log_addr_q;
  assign log_rdata  = log_rdata_q;

endmodule

// File: tb/tb_xc_mem_txn_seq.sv
// tb_xc_mem_txn_seq: directed scoreboard bench for xc_mem_txn_seq.
// Inputs driven at posedge+1/+2, outputs sampled on the falling edge.
module tb_xc_mem_txn_seq;

  logic         g_clk = 1'b0;
  logic         g_resetn;
  logic         req_valid, req_ready, req_wen;
  logic [2:0]   req_count;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_ben;
  logic         mem_cen, mem_wen, mem_stall, mem_error;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_ben;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_rdata;
  logic [2:0]   rsp_result;
  logic [3:0]   log_cen, log_wen, log_error;
  logic [127:0] log_addr, log_rdata;

  xc_mem_txn_seq dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_count(req_count), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ben(req_ben),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ben(mem_ben), .mem_stall(mem_stall),
    .mem_error(mem_error), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_result(rsp_result),
    .log_cen(log_cen), .log_wen(log_wen), .log_error(log_error),
    .log_addr(log_addr), .log_rdata(log_rdata)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [127:0] rdata;
    logic [2:0]   res;
    logic [3:0]   cen, wen, err;
    logic [127:0] addr, lrd;
    int           lat;
  } rsp_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr, wdata;
    logic [3:0]  ben;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Bus responder state.
  int           stall_tab[4];
  int           slot, stall_left, err_slot;
  bit           pend_done;
  logic [127:0] rd_cur;

  // Responder: drives stall/error/rdata for the slot now on the bus.
  always @(posedge g_clk) begin
    #1;
    if (pend_done) begin
      slot++;
      stall_left = (slot < 4) ? stall_tab[slot] : 0;
    end
    if (mem_cen) begin
      if (stall_left > 0) begin
        mem_stall = 1'b1;
        mem_error = 1'b1;
        mem_rdata = 32'hBAD0_0000 | slot;
        stall_left--;
      end else begin
        mem_stall = 1'b0;
        mem_error = (slot == err_slot);
        mem_rdata = rd_cur[32*slot +: 32];
      end
    end else begin
      mem_stall = 1'b0;
      mem_error = 1'b0;
      mem_rdata = '0;
    end
    pend_done = mem_cen && !mem_stall;
  end

  // Bus monitor: completed words against expected, held words must not move.
  bit   hold_v = 0;
  bus_t hold_s;
  always @(negedge g_clk) begin
    if (!g_resetn) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("stall_hold_cen", mem_cen, 1'b1);
        chk("stall_hold_bus", {mem_wen, mem_addr, mem_wdata, mem_ben},
            {hold_s.wen, hold_s.addr, hold_s.wdata, hold_s.ben});
      end
      hold_v = mem_cen && mem_stall;
      hold_s = '{mem_wen, mem_addr, mem_wdata, mem_ben};
      if (mem_cen && !mem_stall) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_bus", {mem_wen, mem_addr}, '0);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_wen", mem_wen, b.wen);
          chk("bus_addr", mem_addr, b.addr);
          chk("bus_wdata", mem_wdata, b.wdata);
          chk("bus_ben", mem_ben, b.ben);
        end
      end
    end
  end

  // Response monitor: latency, hold stability and scoreboard pop.
  int           nneg = 0, acc_n = 0;
  bit           prev_v = 0, prev_rdy = 0;
  logic [127:0] s_rd, s_la, s_lr;
  logic [14:0]  s_misc;
  always @(negedge g_clk) begin
    nneg++;
    if (!g_resetn) begin
      prev_v = 0;
    end else begin
      if (req_valid && req_ready) acc_n = nneg;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          if (!prev_v) chk("latency", nneg - acc_n, rsp_q[0].lat);
          if (prev_v && !prev_rdy) begin
            chk("hold_rdata", rsp_rdata, s_rd);
            chk("hold_laddr", log_addr, s_la);
            chk("hold_lrdata", log_rdata, s_lr);
            chk("hold_misc", {rsp_result, log_cen, log_wen, log_error}, s_misc);
            chk("hold_req_ready", req_ready, 1'b0);
          end
          if (rsp_ready) begin
            rsp_t e;
            e = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_result", rsp_result, e.res);
            chk("log_cen", log_cen, e.cen);
            chk("log_wen", log_wen, e.wen);
            chk("log_error", log_error, e.err);
            chk("log_addr", log_addr, e.addr);
            chk("log_rdata", log_rdata, e.lrd);
          end
        end
      end
      s_rd   = rsp_rdata;
      s_la   = log_addr;
      s_lr   = log_rdata;
      s_misc = {rsp_result, log_cen, log_wen, log_error};
      prev_v   = rsp_valid;
      prev_rdy = rsp_ready;
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #2;
  endtask

  task automatic issue(input int cnt, input bit wen,
                       input logic [127:0] a, input logic [127:0] wd,
                       input logic [127:0] rd, input logic [15:0] be,
                       input int err, input logic [2:0] res, input int lat);
    rsp_t e;
    bus_t b;
    int   n;
    int   w;
    e = '{rdata: '0, res: res, cen: '0, wen: '0, err: '0,
          addr: '0, lrd: '0, lat: lat};
    n = (res >= 3'd2) ? 0 : ((err < cnt) ? err + 1 : cnt);
    for (int k = 0; k < n; k++) begin
      b = '{wen, a[32*k +: 32], wd[32*k +: 32], be[4*k +: 4]};
      bus_q.push_back(b);
      e.cen[k] = 1'b1;
      e.wen[k] = wen;
      e.err[k] = (k == err);
      e.addr[32*k +: 32] = a[32*k +: 32];
      e.lrd[32*k +: 32]  = rd[32*k +: 32];
      if (!wen) e.rdata[32*k +: 32] = rd[32*k +: 32];
    end
    rsp_q.push_back(e);
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    slot       = 0;
    stall_left = stall_tab[0];
    pend_done  = 0;
    err_slot   = err;
    rd_cur     = rd;
    req_valid  = 1'b1;
    req_count  = cnt[2:0];
    req_wen    = wen;
    req_addr   = a;
    req_wdata  = wd;
    req_ben    = be;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic wait_rsp();
    int w;
    w = 0;
    while (rsp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    if (rsp_q.size() != 0) begin
      chk("rsp_timeout", rsp_q.size(), 0);
      rsp_q.delete();
      bus_q.delete();
    end
    tick();
  endtask

  task automatic chk_reset_outs();
    chk("rst_mem_cen", mem_cen, 1'b0);
    chk("rst_mem_bus", {mem_wen, mem_addr, mem_wdata, mem_ben}, '0);
    chk("rst_rsp", {rsp_valid, rsp_result}, '0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rdata", rsp_rdata, '0);
    chk("rst_logs", {log_cen, log_wen, log_error}, '0);
    chk("rst_laddr", log_addr | log_rdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    g_resetn  = 1'b0;
    req_valid = 1'b0;
    req_count = '0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_ben   = '0;
    rsp_ready = 1'b1;
    mem_stall = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    stall_tab = '{0, 0, 0, 0};
    slot = 0; stall_left = 0; err_slot = 9; pend_done = 0; rd_cur = '0;
    repeat (3) tick();
    chk_reset_outs();
    g_resetn = 1'b1;
    tick();

    // Four-word read, no stall.
    issue(4, 1'b0, {32'h10C, 32'h108, 32'h104, 32'h100}, '0,
          {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF, 9, 3'd0, 5);
    wait_rsp();

    // Two-word write, slot 1 stalled three cycles (error ignored while stalled).
    stall_tab = '{0, 3, 0, 0};
    issue(2, 1'b1, {64'h0, 32'h204, 32'h200},
          {64'h0, 32'h1111_2222, 32'h3333_4444},
          {64'h0, 32'h77, 32'h66}, 16'h00F3, 9, 3'd0, 6);
    wait_rsp();
    stall_tab = '{0, 0, 0, 0};

    // Three-word read, error on slot 1.
    issue(3, 1'b0, {32'h0, 32'h308, 32'h304, 32'h300}, '0,
          {32'h0, 32'hC2, 32'hC1, 32'hC0}, 16'hFFFF, 1, 3'd1, 3);
    wait_rsp();

    // Bad counts; count 5 with a misaligned slot still reports bad count.
    issue(0, 1'b0, {32'h0, 32'h0, 32'h0, 32'h600}, '0, '0, 16'hFFFF,
          9, 3'd3, 1);
    wait_rsp();
    issue(5, 1'b0, {32'h60C, 32'h608, 32'h604, 32'h601}, '0, '0,
          16'hFFFF, 9, 3'd3, 1);
    wait_rsp();

    // Misaligned single word.
`ifdef XC_MEM_TXN_SEQ_ALIGN_CHECK_EN
    issue(1, 1'b0, {96'h0, 32'h102}, '0, {96'h0, 32'hD0}, 16'h000F,
          9, 3'd2, 1);
`else
    issue(1, 1'b0, {96'h0, 32'h102}, '0, {96'h0, 32'hD0}, 16'h000F,
          9, 3'd0, 2);
`endif
    wait_rsp();

    // Response back-pressure for five cycles.
    rsp_ready = 1'b0;
    issue(1, 1'b0, {96'h0, 32'h400}, '0, {96'h0, 32'hE0}, 16'h000F,
          9, 3'd0, 2);
    w = 0;
    while (!rsp_valid && w < 50) begin
      tick();
      w++;
    end
    chk("rsp_valid_wait", rsp_valid, 1'b1);
    repeat (5) tick();
    rsp_ready = 1'b1;
    wait_rsp();

    // Reset while a stalled word is on the bus.
    stall_tab = '{20, 0, 0, 0};
    issue(2, 1'b0, {64'h0, 32'h504, 32'h500}, '0,
          {64'h0, 32'hF1, 32'hF0}, 16'h00FF, 9, 3'd0, 3);
    w = 0;
    while (!mem_cen && w < 20) begin
      tick();
      w++;
    end
    chk("abort_cen_before", mem_cen, 1'b1);
    g_resetn = 1'b0;
    #1;
    chk_reset_outs();
    rsp_q.delete();
    bus_q.delete();
    stall_tab = '{0, 0, 0, 0};
    repeat (2) tick();
    chk_reset_outs();
    g_resetn = 1'b1;
    tick();
    chk("post_rst_req_ready", req_ready, 1'b1);

    // Normal request after the reset.
    issue(2, 1'b0, {64'h0, 32'h704, 32'h700}, '0,
          {64'h0, 32'h5A5A_0001, 32'h5A5A_0000}, 16'h00FF, 9, 3'd0, 3);
    wait_rsp();
    chk("bus_q_drained", bus_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
